// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: squash NOP, BTB counter
// encodings, PC stride and the saturating counter step.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST = 32'h2000_0000;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int unsigned PC_INC = 4;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup port plus a
// single training write port driven by resolved branches.
module fetch_btb #(
  parameter int unsigned PC_BITS = 12,
  parameter int unsigned BTB_IDX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_BITS-1:0] rd_pc,
  output logic               rd_taken,
  output logic [PC_BITS-1:0] rd_target,
  input  logic               wr_en,
  input  logic [PC_BITS-1:0] wr_pc,
  input  logic [PC_BITS-1:0] wr_target,
  input  logic               wr_taken
);
  import fetch_unit_pkg::*;

  localparam int unsigned DEPTH = 1 << BTB_IDX;
  localparam int unsigned TAG_W = PC_BITS - BTB_IDX - 2;

  logic               valid  [DEPTH];
  logic [TAG_W-1:0]   tag    [DEPTH];
  logic [PC_BITS-1:0] target [DEPTH];
  logic [1:0]         ctr    [DEPTH];

  logic [BTB_IDX-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]   rd_tag, wr_tag;
  logic               wr_hit;

  assign rd_idx = rd_pc[BTB_IDX+1:2];
  assign rd_tag = rd_pc[PC_BITS-1:BTB_IDX+2];
  assign wr_idx = wr_pc[BTB_IDX+1:2];
  assign wr_tag = wr_pc[PC_BITS-1:BTB_IDX+2];

  assign rd_taken  = valid[rd_idx] && (tag[rd_idx] == rd_tag) && ctr[rd_idx][1];
  assign rd_target = target[rd_idx];
  assign wr_hit    = valid[wr_idx] && (tag[wr_idx] == wr_tag);

  // Word-aligned PCs: the byte-offset bits carry no information here.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{rd_pc[1:0], wr_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_WNT;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr[wr_idx] <= ctr_step(ctr[wr_idx], wr_taken);
        if (wr_taken) target[wr_idx] <= wr_target;
      end else if (wr_taken) begin
        valid[wr_idx]  <= 1'b1;
        tag[wr_idx]    <= wr_tag;
        target[wr_idx] <= wr_target;
        ctr[wr_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BTB-predicted next-PC selection and
// squash of the fetch slot behind an EX redirect.
module fetch_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_BITS = 12,
  parameter int unsigned BTB_IDX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_D,
  input  logic               MEM_stall,
  input  logic               EX_redirect,
  input  logic [PC_BITS-1:0] EX_redirect_pc,
  input  logic               EX_update,
  input  logic [PC_BITS-1:0] EX_pc,
  input  logic [PC_BITS-1:0] EX_target,
  input  logic               EX_br_taken,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [PC_BITS-1:0] F_pc,
  output logic [XLEN-1:0]    F_inst,
  output logic               F_BP_taken
);
  import fetch_unit_pkg::*;

  logic [PC_BITS-1:0] pc_q, pred_next, bp_target;
  logic               bp_taken, squash, train_en;

  assign squash   = EX_redirect && !MEM_stall;
  assign train_en = EX_update && !MEM_stall;

  fetch_btb #(
    .PC_BITS (PC_BITS),
    .BTB_IDX (BTB_IDX)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (pc_q),
    .rd_taken  (bp_taken),
    .rd_target (bp_target),
    .wr_en     (train_en),
    .wr_pc     (EX_pc),
    .wr_target (EX_target),
    .wr_taken  (EX_br_taken)
  );

  assign pred_next = bp_taken ? bp_target : pc_q + PC_BITS'(PC_INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else if (!MEM_stall) begin
      if (EX_redirect)  pc_q <= EX_redirect_pc;
      else if (!stall_D) pc_q <= pred_next;
    end
  end

  assign F_pc       = pc_q;
  assign imem_addr  = pc_q;
  assign F_inst     = squash ? XLEN'(NOP_INST) : imem_rdata;
  assign F_BP_taken = bp_taken && !squash;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected next fetch PCs go into a
// scoreboard queue as stimulus is applied and are popped after each edge.
module tb_fetch_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_BITS = 12;
  localparam int unsigned BTB_IDX = 4;
  localparam logic [31:0] NOP     = 32'h2000_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall_D, MEM_stall, EX_redirect, EX_update, EX_br_taken;
  logic [PC_BITS-1:0] EX_redirect_pc, EX_pc, EX_target;
  logic [PC_BITS-1:0] imem_addr, F_pc;
  logic [XLEN-1:0]    imem_rdata, F_inst;
  logic               F_BP_taken;

  int checks = 0;
  int errors = 0;
  logic [PC_BITS-1:0] exp_q [$];
  logic [PC_BITS-1:0] e;

  fetch_unit #(
    .XLEN    (XLEN),
    .PC_BITS (PC_BITS),
    .BTB_IDX (BTB_IDX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_D        (stall_D),
    .MEM_stall      (MEM_stall),
    .EX_redirect    (EX_redirect),
    .EX_redirect_pc (EX_redirect_pc),
    .EX_update      (EX_update),
    .EX_pc          (EX_pc),
    .EX_target      (EX_target),
    .EX_br_taken    (EX_br_taken),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .F_pc           (F_pc),
    .F_inst         (F_inst),
    .F_BP_taken     (F_BP_taken)
  );

  always #5 clk = ~clk;

  // Instruction memory returns a word tagged with its own address.
  assign imem_rdata = {20'hC0DE0, imem_addr};

  function automatic logic [31:0] inst_of(input logic [PC_BITS-1:0] a);
    return {20'hC0DE0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ms, input logic sd, input logic rd, input logic [PC_BITS-1:0] rpc,
                       input logic up, input logic [PC_BITS-1:0] upc, input logic [PC_BITS-1:0] utgt,
                       input logic utk);
    MEM_stall = ms; stall_D = sd; EX_redirect = rd; EX_redirect_pc = rpc;
    EX_update = up; EX_pc = upc; EX_target = utgt; EX_br_taken = utk;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, 0, '0, '0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    checks++;
    if (F_pc !== 12'h000) begin errors++; $display("FAIL reset_pc got %h want 000", F_pc); end
    checks++;
    if (imem_addr !== 12'h000) begin errors++; $display("FAIL reset_imem_addr got %h want 000", imem_addr); end
    checks++;
    if (F_BP_taken !== 1'b0) begin errors++; $display("FAIL reset_bp got %b want 0", F_BP_taken); end
    rst = 1'b0;
    #1;
    checks++;
    if (F_inst !== inst_of(12'h000)) begin errors++; $display("FAIL reset_inst got %h want %h", F_inst, inst_of(12'h000)); end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 8; i++) begin
      logic [PC_BITS-1:0] pc;
      pc = PC_BITS'(4 * i);
      idle();
      checks++;
      if (F_BP_taken !== 1'b0) begin errors++; $display("FAIL free_bp pc %h got %b want 0", pc, F_BP_taken); end
      checks++;
      if (F_inst !== inst_of(pc)) begin errors++; $display("FAIL free_inst got %h want %h", F_inst, inst_of(pc)); end
      exp_q.push_back(pc + 12'd4);
      tick();
      e = exp_q.pop_front(); checks++;
      if (F_pc !== e) begin errors++; $display("FAIL free_pc got %h want %h", F_pc, e); end
    end
  endtask

  task automatic test_btb_alloc();
    drive(0, 0, 0, '0, 1, 12'h010, 12'h040, 1);
    exp_q.push_back(12'h024);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL alloc_pc0 got %h want %h", F_pc, e); end
    drive(0, 0, 1, 12'h010, 0, '0, '0, 0);
    exp_q.push_back(12'h010);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL alloc_pc1 got %h want %h", F_pc, e); end
    idle();
    checks++;
    if (F_BP_taken !== 1'b1) begin errors++; $display("FAIL alloc_bp got %b want 1", F_BP_taken); end
    checks++;
    if (F_inst !== inst_of(12'h010)) begin errors++; $display("FAIL alloc_inst got %h want %h", F_inst, inst_of(12'h010)); end
    exp_q.push_back(12'h040);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL alloc_target got %h want %h", F_pc, e); end
    idle();
    exp_q.push_back(12'h044);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL alloc_after got %h want %h", F_pc, e); end
  endtask

  // Counter walk at 0x010 starting from WT: down twice, floor, up to ST, then down once.
  task automatic test_btb_train();
    logic tk [7];
    logic bp [7];
    tk = '{0, 0, 0, 1, 1, 1, 0};
    bp = '{0, 0, 0, 0, 1, 1, 1};
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 1, 12'h010, 1, 12'h010, 12'h080, tk[k]);
      exp_q.push_back(12'h010);
      tick();
      e = exp_q.pop_front(); checks++;
      if (F_pc !== e) begin errors++; $display("FAIL train_pc step %0d got %h want %h", k, F_pc, e); end
      idle();
      checks++;
      if (F_BP_taken !== bp[k]) begin errors++; $display("FAIL train_bp step %0d got %b want %b", k, F_BP_taken, bp[k]); end
      exp_q.push_back(bp[k] ? 12'h080 : 12'h014);
      tick();
      e = exp_q.pop_front(); checks++;
      if (F_pc !== e) begin errors++; $display("FAIL train_next step %0d got %h want %h", k, F_pc, e); end
    end
  endtask

  task automatic test_redirect();
    drive(0, 0, 1, 12'h020, 0, '0, '0, 0);
    exp_q.push_back(12'h020);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL redir_pc0 got %h want %h", F_pc, e); end
    drive(0, 0, 1, 12'h100, 0, '0, '0, 0);
    checks++;
    if (F_inst !== NOP) begin errors++; $display("FAIL redir_nop got %h want %h", F_inst, NOP); end
    checks++;
    if (F_BP_taken !== 1'b0) begin errors++; $display("FAIL redir_bp got %b want 0", F_BP_taken); end
    exp_q.push_back(12'h100);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL redir_pc1 got %h want %h", F_pc, e); end
    // Squash must also mask a BTB hit (0x010 is predicted taken here).
    drive(0, 0, 1, 12'h010, 0, '0, '0, 0);
    exp_q.push_back(12'h010);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL redir_pc2 got %h want %h", F_pc, e); end
    drive(0, 0, 1, 12'h100, 0, '0, '0, 0);
    checks++;
    if (F_BP_taken !== 1'b0) begin errors++; $display("FAIL redir_hit_bp got %b want 0", F_BP_taken); end
    exp_q.push_back(12'h100);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL redir_pc3 got %h want %h", F_pc, e); end
    drive(0, 0, 1, 12'hFFC, 0, '0, '0, 0);
    exp_q.push_back(12'hFFC);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL redir_pc4 got %h want %h", F_pc, e); end
    idle();
    exp_q.push_back(12'h000);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL wrap_pc got %h want %h", F_pc, e); end
  endtask

  task automatic test_mem_stall();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 12'h300, 1, 12'h034, 12'h0C0, 1);
      checks++;
      if (F_inst !== inst_of(12'h000)) begin errors++; $display("FAIL mstall_inst got %h want %h", F_inst, inst_of(12'h000)); end
      exp_q.push_back(12'h000);
      tick();
      e = exp_q.pop_front(); checks++;
      if (F_pc !== e) begin errors++; $display("FAIL mstall_hold got %h want %h", F_pc, e); end
    end
    drive(0, 0, 1, 12'h300, 1, 12'h030, 12'h0C0, 1);
    checks++;
    if (F_inst !== NOP) begin errors++; $display("FAIL mstall_release_nop got %h want %h", F_inst, NOP); end
    exp_q.push_back(12'h300);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL mstall_release_pc got %h want %h", F_pc, e); end
    drive(0, 0, 1, 12'h030, 0, '0, '0, 0);
    exp_q.push_back(12'h030);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL mstall_pc030 got %h want %h", F_pc, e); end
    idle();
    checks++;
    if (F_BP_taken !== 1'b1) begin errors++; $display("FAIL mstall_trained_bp got %b want 1", F_BP_taken); end
    exp_q.push_back(12'h0C0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL mstall_target got %h want %h", F_pc, e); end
    drive(0, 0, 1, 12'h034, 0, '0, '0, 0);
    exp_q.push_back(12'h034);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL mstall_pc034 got %h want %h", F_pc, e); end
    idle();
    checks++;
    if (F_BP_taken !== 1'b0) begin errors++; $display("FAIL mstall_blocked_bp got %b want 0", F_BP_taken); end
    exp_q.push_back(12'h038);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL mstall_seq got %h want %h", F_pc, e); end
  endtask

  task automatic test_stall_d();
    drive(0, 0, 1, 12'h008, 0, '0, '0, 0);
    exp_q.push_back(12'h008);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL stalld_pc got %h want %h", F_pc, e); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, '0, (i == 0), 12'h050, 12'h0A0, 1);
      checks++;
      if (F_inst !== inst_of(12'h008)) begin errors++; $display("FAIL stalld_inst got %h want %h", F_inst, inst_of(12'h008)); end
      exp_q.push_back(12'h008);
      tick();
      e = exp_q.pop_front(); checks++;
      if (F_pc !== e) begin errors++; $display("FAIL stalld_hold cycle %0d got %h want %h", i, F_pc, e); end
    end
    drive(0, 1, 1, 12'h200, 0, '0, '0, 0);
    checks++;
    if (F_inst !== NOP) begin errors++; $display("FAIL stalld_redir_nop got %h want %h", F_inst, NOP); end
    exp_q.push_back(12'h200);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL stalld_redir_pc got %h want %h", F_pc, e); end
    drive(0, 0, 1, 12'h050, 0, '0, '0, 0);
    exp_q.push_back(12'h050);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL stalld_pc050 got %h want %h", F_pc, e); end
    idle();
    checks++;
    if (F_BP_taken !== 1'b1) begin errors++; $display("FAIL stalld_trained_bp got %b want 1", F_BP_taken); end
    exp_q.push_back(12'h0A0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL stalld_target got %h want %h", F_pc, e); end
    // 0x050 shares an index with 0x010 and replaced it.
    drive(0, 0, 1, 12'h010, 0, '0, '0, 0);
    exp_q.push_back(12'h010);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL replace_pc got %h want %h", F_pc, e); end
    idle();
    checks++;
    if (F_BP_taken !== 1'b0) begin errors++; $display("FAIL replace_bp got %b want 0", F_BP_taken); end
    exp_q.push_back(12'h014);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL replace_next got %h want %h", F_pc, e); end
  endtask

  task automatic test_same_index();
    drive(0, 0, 1, 12'h060, 0, '0, '0, 0);
    exp_q.push_back(12'h060);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL same_pc got %h want %h", F_pc, e); end
    drive(0, 0, 0, '0, 1, 12'h060, 12'h0E0, 1);
    checks++;
    if (F_BP_taken !== 1'b0) begin errors++; $display("FAIL same_prewrite_bp got %b want 0", F_BP_taken); end
    exp_q.push_back(12'h064);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL same_next got %h want %h", F_pc, e); end
    drive(0, 0, 1, 12'h060, 0, '0, '0, 0);
    exp_q.push_back(12'h060);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL same_pc2 got %h want %h", F_pc, e); end
    idle();
    checks++;
    if (F_BP_taken !== 1'b1) begin errors++; $display("FAIL same_postwrite_bp got %b want 1", F_BP_taken); end
    exp_q.push_back(12'h0E0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL same_target got %h want %h", F_pc, e); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    drive(0, 0, 0, '0, 1, 12'h070, 12'h0F0, 1);
    exp_q.push_back(12'h000);
    tick();
    rst = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL rstmid_pc got %h want %h", F_pc, e); end
    idle();
    checks++;
    if (F_inst !== inst_of(12'h000)) begin errors++; $display("FAIL rstmid_inst got %h want %h", F_inst, inst_of(12'h000)); end
    exp_q.push_back(12'h004);
    tick();
    e = exp_q.pop_front(); checks++;
    if (F_pc !== e) begin errors++; $display("FAIL rstmid_first got %h want %h", F_pc, e); end
    for (int i = 0; i < 2; i++) begin
      logic [PC_BITS-1:0] a;
      a = (i == 0) ? 12'h060 : 12'h070;
      drive(0, 0, 1, a, 0, '0, '0, 0);
      exp_q.push_back(a);
      tick();
      e = exp_q.pop_front(); checks++;
      if (F_pc !== e) begin errors++; $display("FAIL rstmid_redir got %h want %h", F_pc, e); end
      idle();
      checks++;
      if (F_BP_taken !== 1'b0) begin errors++; $display("FAIL rstmid_cleared_bp pc %h got %b want 0", a, F_BP_taken); end
      exp_q.push_back(a + 12'd4);
      tick();
      e = exp_q.pop_front(); checks++;
      if (F_pc !== e) begin errors++; $display("FAIL rstmid_seq got %h want %h", F_pc, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run();
    test_btb_alloc();
    test_btb_train();
    test_redirect();
    test_mem_stall();
    test_stall_d();
    test_same_index();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
